// File: rtl/uart_rx_oversampled.sv
// uart_rx_oversampled: 8N1 UART receiver that derives its own 16x oversample
// tick from the baud select and recovers frames from the serial line rx.
//
// Optional feature macro: UART_RX_PARITY_EN adds one parity bit between the
// data bits and the stop bit; ODD_PARITY selects even (0) or odd (1) sense.
// Without the macro the receiver is plain 8N1 and parity_err is always 0.
//
// Handshake: a delivered byte raises rx_ready, which stays high until rx_ack
// is seen while rx_ready is high; rx_ack while rx_ready is low is ignored.
// A delivery while rx_ready is still high (and not acked in that same cycle)
// sets the sticky overrun flag, which rx_ack also clears.
module uart_rx_oversampled #(
    parameter int DIV0       = 325,
    parameter int DIV1       = 162,
    parameter int DIV2       = 80,
    parameter int DIV3       = 26,
    parameter int ODD_PARITY = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] sel,
    input  logic       rx,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_ready,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t      state;
    logic        rx_meta;
    logic        rx_sync;
    logic        rx_prev;
    logic [1:0]  sel_q;
    logic [11:0] tick_cnt;
    logic [11:0] div_sel;
    logic        tick;
    logic [3:0]  sample_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift_reg;
    logic        s7;
    logic        s8;
    logic        vote;
    logic        vote_now;
    logic        bit_end;
`ifdef UART_RX_PARITY_EN
    logic        par_bit;
`endif

    // Two-flop synchronizer plus one history flop for falling-edge detection.
    // All preset to 1 so releasing reset never looks like a start bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // Terminal count for the baud rate latched at start-bit detection.
    always_comb begin
        div_sel = 12'(DIV0);
        case (sel_q)
            2'b00:   div_sel = 12'(DIV0);
            2'b01:   div_sel = 12'(DIV1);
            2'b10:   div_sel = 12'(DIV2);
            default: div_sel = 12'(DIV3);
        endcase
    end

    assign tick     = (tick_cnt == div_sel);
    assign vote_now = tick && (sample_cnt == 4'd9);
    assign bit_end  = tick && (sample_cnt == 4'd15);
    // 2-of-3 majority of the samples at ticks 7, 8 and the live one at tick 9.
    assign vote     = (s7 & s8) | (s7 & rx_sync) | (s8 & rx_sync);
    assign busy     = (state != IDLE);

`ifndef UART_RX_PARITY_EN
    // No parity bit on the line, so no parity error; ODD_PARITY has no meaning.
    assign parity_err = 1'b0 & (ODD_PARITY != 0);
`endif

    // Frame FSM with its bit-timing counters, shift register and output flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            sel_q      <= 2'b00;
            tick_cnt   <= 12'd0;
            sample_cnt <= 4'd0;
            bit_cnt    <= 3'd0;
            shift_reg  <= 8'h00;
            s7         <= 1'b1;
            s8         <= 1'b1;
            rx_data    <= 8'h00;
            rx_ready   <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            // Consumer acknowledge; a delivery below in the same cycle overrides.
            if (rx_ack && rx_ready) begin
                rx_ready <= 1'b0;
                overrun  <= 1'b0;
            end

            if (state == IDLE) begin
                tick_cnt   <= 12'd0;
                sample_cnt <= 4'd0;
                // Only a 1->0 transition starts a frame; a line held low does not.
                if (rx_prev && !rx_sync) begin
                    state <= START;
                    sel_q <= sel;
                end
            end else begin
                if (tick) begin
                    tick_cnt   <= 12'd0;
                    sample_cnt <= sample_cnt + 4'd1;
                end else begin
                    tick_cnt <= tick_cnt + 12'd1;
                end
                if (tick && (sample_cnt == 4'd7)) begin
                    s7 <= rx_sync;
                end
                if (tick && (sample_cnt == 4'd8)) begin
                    s8 <= rx_sync;
                end

                case (state)
                    START: begin
                        if (vote_now && vote) begin
                            // Glitch rather than a real start bit: drop it silently.
                            state <= IDLE;
                        end else if (bit_end) begin
                            state   <= DATA;
                            bit_cnt <= 3'd0;
                        end
                    end
                    DATA: begin
                        if (vote_now) begin
                            shift_reg <= {vote, shift_reg[7:1]};
                        end
                        if (bit_end) begin
                            if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    PARITY: begin
                        if (vote_now) begin
                            par_bit <= vote;
                        end
                        if (bit_end) begin
                            state <= STOP;
                        end
                    end
`endif
                    STOP: begin
                        // Deliver mid stop bit and go idle half a bit early so a
                        // following start bit is caught without loss.
                        if (vote_now) begin
                            rx_data   <= shift_reg;
                            rx_ready  <= 1'b1;
                            frame_err <= ~vote;
                            overrun   <= (rx_ready | overrun) & ~rx_ack;
`ifdef UART_RX_PARITY_EN
                            parity_err <= ((^shift_reg) ^ par_bit) != (ODD_PARITY != 0);
`endif
                            state     <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// tb_uart_rx_oversampled: directed bench for the UART receiver at DIV3=3,
// sel=11 (4 clk per tick, 64 clk per bit). A table of frames covers the main
// receive path; hand-written sequences cover false start, line held low,
// back-to-back overrun, mid-frame reset and (with the macro) parity.
module tb_uart_rx_oversampled;

    localparam int BIT_CLKS = 64;

    logic       clk;
    logic       reset_n;
    logic [1:0] sel;
    logic       rx;
    logic       rx_ack;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;
    logic       busy;

    int errors;
    int checks;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        logic [7:0] exp_data;
        logic       exp_frame_err;
    } vec_t;

    vec_t vecs[5];

    uart_rx_oversampled #(
        .DIV0(325), .DIV1(162), .DIV2(80), .DIV3(3), .ODD_PARITY(0)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sel        (sel),
        .rx         (rx),
        .rx_ack     (rx_ack),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Compare rx_data against the oldest expected byte in the queue.
    task automatic check_data(input string name);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: no expected byte queued, got %h", name, rx_data);
        end else begin
            e = exp_q.pop_front();
            check(name, rx_data, e);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        wait_clks(BIT_CLKS);
    endtask

    // Start bit, 8 data bits LSB first, [even parity], stop bit. rx is left
    // at the stop-bit level so callers can hold the line afterwards.
    task automatic send_byte(input logic [7:0] d, input logic stop_b);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(^d);
`endif
        send_bit(stop_b);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_byte_par(input logic [7:0] d, input logic p);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(p);
        send_bit(1'b1);
    endtask
`endif

    task automatic pulse_ack;
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic saw_busy;
        errors  = 0;
        checks  = 0;
        reset_n = 1'b0;
        sel     = 2'b11;
        rx      = 1'b1;
        rx_ack  = 1'b0;

        vecs[0] = '{data: 8'hA5, stop_bit: 1'b1, exp_data: 8'hA5, exp_frame_err: 1'b0};
        vecs[1] = '{data: 8'h00, stop_bit: 1'b1, exp_data: 8'h00, exp_frame_err: 1'b0};
        vecs[2] = '{data: 8'hFF, stop_bit: 1'b1, exp_data: 8'hFF, exp_frame_err: 1'b0};
        vecs[3] = '{data: 8'h6E, stop_bit: 1'b0, exp_data: 8'h6E, exp_frame_err: 1'b1};
        vecs[4] = '{data: 8'h81, stop_bit: 1'b1, exp_data: 8'h81, exp_frame_err: 1'b0};

        // Reset state
        wait_clks(5);
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_rx_ready", {7'd0, rx_ready}, 8'h00);
        check("reset_frame_err", {7'd0, frame_err}, 8'h00);
        check("reset_parity_err", {7'd0, parity_err}, 8'h00);
        check("reset_overrun", {7'd0, overrun}, 8'h00);
        check("reset_busy", {7'd0, busy}, 8'h00);
        reset_n = 1'b1;
        wait_clks(10);
        check("idle_after_release_busy", {7'd0, busy}, 8'h00);

        // Table-driven frames, each acknowledged afterwards
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(vecs[i].exp_data);
            send_byte(vecs[i].data, vecs[i].stop_bit);
            rx = 1'b1;
            wait_clks(4);
            check_data("vec_rx_data");
            check("vec_rx_ready", {7'd0, rx_ready}, 8'h01);
            check("vec_frame_err", {7'd0, frame_err}, {7'd0, vecs[i].exp_frame_err});
            check("vec_parity_err", {7'd0, parity_err}, 8'h00);
            check("vec_overrun", {7'd0, overrun}, 8'h00);
            check("vec_busy", {7'd0, busy}, 8'h00);
            pulse_ack();
            check("vec_ready_after_ack", {7'd0, rx_ready}, 8'h00);
            wait_clks(BIT_CLKS);
        end

        // False start: 20 clk low pulse
        rx = 1'b0;
        wait_clks(10);
        check("false_start_busy_high", {7'd0, busy}, 8'h01);
        wait_clks(10);
        rx = 1'b1;
        wait_clks(60);
        check("false_start_busy_low", {7'd0, busy}, 8'h00);
        check("false_start_no_ready", {7'd0, rx_ready}, 8'h00);

        // Framing error with the line held low afterwards: no retrigger
        exp_q.push_back(8'h3C);
        send_byte(8'h3C, 1'b0);
        saw_busy = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (busy) saw_busy = 1'b1;
        end
        check("held_low_no_restart", {7'd0, saw_busy}, 8'h00);
        check_data("frame_err_rx_data");
        check("frame_err_flag", {7'd0, frame_err}, 8'h01);
        check("frame_err_ready", {7'd0, rx_ready}, 8'h01);
        pulse_ack();
        rx = 1'b1;
        wait_clks(BIT_CLKS);
        exp_q.push_back(8'h96);
        send_byte(8'h96, 1'b1);
        wait_clks(4);
        check_data("after_low_rx_data");
        check("after_low_frame_err", {7'd0, frame_err}, 8'h00);
        pulse_ack();

        // Back-to-back frames without acknowledge
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        wait_clks(4);
        exp_q.push_back(8'h22);
        check_data("b2b_rx_data");
        check("b2b_ready", {7'd0, rx_ready}, 8'h01);
        check("b2b_overrun", {7'd0, overrun}, 8'h01);
        pulse_ack();
        check("b2b_ready_after_ack", {7'd0, rx_ready}, 8'h00);
        check("b2b_overrun_after_ack", {7'd0, overrun}, 8'h00);
        pulse_ack();
        check("ack_when_idle_ignored", {7'd0, rx_ready}, 8'h00);

        // Reset during data bit 4 with an unacknowledged byte pending
        send_byte(8'hC3, 1'b1);
        wait_clks(BIT_CLKS);
        check("pre_reset_ready", {7'd0, rx_ready}, 8'h01);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rx = 1'b0;
        wait_clks(20);
        check("mid_frame_busy", {7'd0, busy}, 8'h01);
        reset_n = 1'b0;
        @(negedge clk);
        check("mid_reset_rx_data", rx_data, 8'h00);
        check("mid_reset_ready", {7'd0, rx_ready}, 8'h00);
        check("mid_reset_frame_err", {7'd0, frame_err}, 8'h00);
        check("mid_reset_overrun", {7'd0, overrun}, 8'h00);
        check("mid_reset_busy", {7'd0, busy}, 8'h00);
        rx = 1'b1;
        wait_clks(4);
        reset_n = 1'b1;
        wait_clks(10);
        exp_q.push_back(8'h5A);
        send_byte(8'h5A, 1'b1);
        wait_clks(4);
        check_data("post_reset_rx_data");
        check("post_reset_ready", {7'd0, rx_ready}, 8'h01);
        check("post_reset_overrun", {7'd0, overrun}, 8'h00);
        pulse_ack();

`ifdef UART_RX_PARITY_EN
        // Parity: 0x07 has odd weight, so even parity needs parity bit 1
        send_byte_par(8'h07, 1'b0);
        wait_clks(4);
        exp_q.push_back(8'h07);
        check_data("par_bad_rx_data");
        check("par_bad_parity_err", {7'd0, parity_err}, 8'h01);
        pulse_ack();
        send_byte_par(8'h07, 1'b1);
        wait_clks(4);
        check("par_good_parity_err", {7'd0, parity_err}, 8'h00);
        pulse_ack();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
